// File: rtl/a2d_chnl_seq.sv
// Round-robin A2D conversion scheduler: left load, right load and battery through one SPI master.
// Build option A2D_SEQ_AVG_EN: each channel register holds a rounded average of old and new samples.

module a2d_chnl_seq #(
    parameter logic [2:0]  LFT_CHNL  = 3'd0,
    parameter logic [2:0]  RGHT_CHNL = 3'd4,
    parameter logic [2:0]  BATT_CHNL = 3'd5,
    parameter int unsigned TMO_W     = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        spi_done,
    input  logic [15:0] spi_rd_data,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        rnd_done,
    output logic        busy,
    output logic        tmo_err
);
    localparam int unsigned DW = 12;

    typedef enum logic [2:0] {IDLE, CMD, WAIT_C, GAP, RD, WAIT_R, CAPT, DONE} state_t;
    typedef enum logic [1:0] {CH_LFT, CH_RGHT, CH_BATT} chnl_t;

    state_t           state;
    chnl_t            chnl;
    logic             pending;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_inc_c;
    logic [DW-1:0]    temp;
    logic [DW-1:0]    capt_val_c;
    logic             unused_rd_bits;

    assign unused_rd_bits = ^spi_rd_data[15:12];
    assign tmo_inc_c      = tmo_cnt + TMO_W'(1);

    function automatic logic [15:0] cmd_word(input chnl_t ch);
        case (ch)
            CH_RGHT: return {2'b00, RGHT_CHNL, 11'h000};
            CH_BATT: return {2'b00, BATT_CHNL, 11'h000};
            default: return {2'b00, LFT_CHNL, 11'h000};
        endcase
    endfunction

`ifdef A2D_SEQ_AVG_EN
    logic [2:0]    primed;
    logic [DW-1:0] old_c;
    logic          primed_c;
    logic [DW:0]   sum_c;

    // Rounded mean of the stored and new sample; first sample per channel is taken as-is.
    always_comb begin
        old_c    = lft_ld;
        primed_c = primed[0];
        case (chnl)
            CH_RGHT: begin old_c = rght_ld; primed_c = primed[1]; end
            CH_BATT: begin old_c = batt;    primed_c = primed[2]; end
            default: begin old_c = lft_ld;  primed_c = primed[0]; end
        endcase
        sum_c      = {1'b0, old_c} + {1'b0, temp} + (DW+1)'(1);
        capt_val_c = primed_c ? sum_c[DW:1] : temp;
    end
`else
    assign capt_val_c = temp;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            chnl     <= CH_LFT;
            pending  <= 1'b0;
            tmo_cnt  <= '0;
            temp     <= '0;
            spi_wrt  <= 1'b0;
            spi_cmd  <= '0;
            lft_ld   <= '0;
            rght_ld  <= '0;
            batt     <= '0;
            rnd_done <= 1'b0;
            busy     <= 1'b0;
            tmo_err  <= 1'b0;
`ifdef A2D_SEQ_AVG_EN
            primed   <= '0;
`endif
        end else begin
            spi_wrt  <= 1'b0;
            rnd_done <= 1'b0;
            tmo_err  <= 1'b0;
            // A request arriving mid-round (including DONE) is remembered, depth one.
            if (nxt && state != IDLE) pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (nxt || pending) begin
                        pending <= 1'b0;
                        spi_wrt <= 1'b1;
                        spi_cmd <= cmd_word(chnl);
                        busy    <= 1'b1;
                        state   <= CMD;
                    end
                end
                CMD: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_C;
                end
                WAIT_C, WAIT_R: begin
                    if (spi_done) begin
                        if (state == WAIT_R) begin
                            temp  <= spi_rd_data[DW-1:0];
                            state <= CAPT;
                        end else begin
                            state <= GAP;
                        end
                    end else if (tmo_inc_c == '1) begin
                        tmo_err <= 1'b1;
                        busy    <= 1'b0;
                        chnl    <= CH_LFT;
                        pending <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_inc_c;
                    end
                end
                GAP: begin
                    spi_wrt <= 1'b1;
                    state   <= RD;
                end
                RD: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_R;
                end
                CAPT: begin
`ifdef A2D_SEQ_AVG_EN
                    primed <= primed | (3'b001 << chnl);
`endif
                    case (chnl)
                        CH_LFT: begin
                            lft_ld  <= capt_val_c;
                            chnl    <= CH_RGHT;
                            spi_cmd <= cmd_word(CH_RGHT);
                            spi_wrt <= 1'b1;
                            state   <= CMD;
                        end
                        CH_RGHT: begin
                            rght_ld <= capt_val_c;
                            chnl    <= CH_BATT;
                            spi_cmd <= cmd_word(CH_BATT);
                            spi_wrt <= 1'b1;
                            state   <= CMD;
                        end
                        default: begin
                            batt     <= capt_val_c;
                            chnl     <= CH_LFT;
                            rnd_done <= 1'b1;
                            busy     <= 1'b0;
                            state    <= DONE;
                        end
                    endcase
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_chnl_seq.sv
// Self-checking bench for a2d_chnl_seq: randomized SPI slave latency/data against a round-level model.
// Honors A2D_SEQ_AVG_EN in its reference model.

module tb_a2d_chnl_seq;
`ifdef A2D_SEQ_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif
    localparam int MAXX = 256;

    logic        clk = 1'b0;
    logic        rst_n, nxt, spi_done;
    logic [15:0] spi_rd_data;
    logic        spi_wrt, rnd_done, busy, tmo_err;
    logic [15:0] spi_cmd;
    logic [11:0] lft_ld, rght_ld, batt;

    a2d_chnl_seq dut (
        .clk(clk), .rst_n(rst_n), .nxt(nxt), .spi_done(spi_done), .spi_rd_data(spi_rd_data),
        .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .lft_ld(lft_ld), .rght_ld(rght_ld), .batt(batt),
        .rnd_done(rnd_done), .busy(busy), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_fail = 0;

    // Transaction log filled by the SPI slave model
    logic [15:0] x_cmd [MAXX];
    logic [15:0] x_dat [MAXX];
    int          x_wrt [MAXX];
    int          x_lat [MAXX];
    bit          x_held[MAXX];
    int          n_x = 0;
    int          hold_idx = -1;
    logic [15:0] data_q[$];

    int rnd_cnt = 0, rnd_cyc = 0, n_tmo = 0, tmo_cyc = 0;

    logic [11:0] m_lft, m_rght, m_batt;
    bit          m_primed[3];

    // SPI slave: answers each spi_wrt after 1..6 cycles unless told to stay silent.
    initial begin : spi_resp
        int i, lat;
        spi_done = 1'b0;
        spi_rd_data = '0;
        forever begin
            @(negedge clk);
            if (spi_wrt === 1'b1 && n_x < MAXX) begin
                i = n_x;
                n_x++;
                x_cmd[i] = spi_cmd; x_wrt[i] = cyc; x_held[i] = 1'b1;
                x_dat[i] = '0; x_lat[i] = 0;
                if (i != hold_idx) begin
                    lat = $urandom_range(1, 6);
                    x_lat[i] = lat;
                    repeat (lat) begin
                        @(negedge clk);
                        if (spi_cmd !== x_cmd[i]) x_held[i] = 1'b0;
                    end
                    if (data_q.size() > 0) x_dat[i] = data_q.pop_front();
                    else x_dat[i] = 16'($urandom);
                    spi_rd_data = x_dat[i];
                    spi_done = 1'b1;
                    @(negedge clk);
                    spi_done = 1'b0;
                    spi_rd_data = 16'($urandom);
                end
            end
        end
    end

    initial begin : observer
        forever begin
            @(negedge clk);
            if (rnd_done === 1'b1) begin rnd_cnt++; rnd_cyc = cyc; end
            if (tmo_err === 1'b1) begin n_tmo++; tmo_cyc = cyc; end
        end
    end

    function automatic logic [11:0] mdl_upd(input logic [11:0] old, input bit primed, input logic [15:0] raw);
        int s;
        s = int'(raw & 16'h0fff);
        if (AVG && primed) return 12'((int'(old) + s + 1) / 2);
        return 12'(s);
    endfunction

    // A round is six transactions; odd ones are the reads carrying L, R, B samples.
    task automatic model_round(input int b);
        m_lft  = mdl_upd(m_lft,  m_primed[0], x_dat[b+1]); m_primed[0] = 1'b1;
        m_rght = mdl_upd(m_rght, m_primed[1], x_dat[b+3]); m_primed[1] = 1'b1;
        m_batt = mdl_upd(m_batt, m_primed[2], x_dat[b+5]); m_primed[2] = 1'b1;
    endtask

    task automatic model_reset();
        m_lft = '0; m_rght = '0; m_batt = '0;
        for (int k = 0; k < 3; k++) m_primed[k] = 1'b0;
    endtask

    function automatic logic [15:0] exp_cmd(input int j);
        case (j / 2)
            0:       return 16'h0000;
            1:       return 16'h2000;
            default: return 16'h2800;
        endcase
    endfunction

    task automatic pulse_nxt(output int c);
        @(negedge clk);
        nxt = 1'b1;
        c = cyc;
        @(negedge clk);
        nxt = 1'b0;
    endtask

    task automatic wait_rnd(input int target, input string tag);
        int k;
        k = 0;
        while (rnd_cnt < target && k < 600) begin @(negedge clk); k++; end
        n_cmp++;
        if (rnd_cnt < target) begin
            n_fail++;
            $display("FAIL %s wait: rounds %0d, required %0d within cycle budget", tag, rnd_cnt, target);
        end
    endtask

    task automatic test_reset();
        nxt = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({spi_wrt, spi_cmd, lft_ld, rght_ld, batt, rnd_done, busy, tmo_err} !== 56'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {spi_wrt, spi_cmd, lft_ld, rght_ld, batt, rnd_done, busy, tmo_err});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (n_x != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: xfers %0d busy %b, required 0 0", n_x, busy);
        end
        model_reset();
    endtask

    task automatic test_basic();
        int b, r0;
        b = n_x; r0 = rnd_cnt;
        data_q.push_back(16'($urandom)); data_q.push_back({4'($urandom), 12'h123});
        data_q.push_back(16'($urandom)); data_q.push_back({4'($urandom), 12'h456});
        data_q.push_back(16'($urandom)); data_q.push_back({4'($urandom), 12'h789});
        @(negedge clk);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        n_cmp++;
        if (spi_wrt !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency: wrt %b busy %b, required 1 1", spi_wrt, busy);
        end
        wait_rnd(r0 + 1, "basic");
        repeat (5) @(negedge clk);
        for (int j = 0; j < 6; j++) begin
            n_cmp++;
            if (x_cmd[b+j] !== exp_cmd(j)) begin
                n_fail++;
                $display("FAIL basic_cmd%0d: got %h, required %h", j, x_cmd[b+j], exp_cmd(j));
            end
        end
        n_cmp++;
        if (lft_ld !== 12'h123 || rght_ld !== 12'h456 || batt !== 12'h789) begin
            n_fail++;
            $display("FAIL basic_regs: got %h %h %h, required 123 456 789", lft_ld, rght_ld, batt);
        end
        n_cmp++;
        if (rnd_cnt != r0 + 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: rounds %0d busy %b, required %0d 0", rnd_cnt - r0, busy, 1);
        end
        model_round(b);
    endtask

    task automatic test_random_rounds();
        int b, r0, nc, sum;
        for (int it = 0; it < 4; it++) begin
            b = n_x; r0 = rnd_cnt;
            pulse_nxt(nc);
            wait_rnd(r0 + 1, "random");
            n_cmp++;
            if (x_wrt[b] - nc != 1) begin
                n_fail++;
                $display("FAIL rnd_nxt_latency: got %0d, required 1", x_wrt[b] - nc);
            end
            sum = 0;
            for (int j = 0; j < 6; j++) begin
                sum += x_lat[b+j];
                n_cmp++;
                if (x_cmd[b+j] !== exp_cmd(j) || !x_held[b+j]) begin
                    n_fail++;
                    $display("FAIL rnd_cmd%0d: got %h held %b, required %h held 1",
                             j, x_cmd[b+j], x_held[b+j], exp_cmd(j));
                end
            end
            // done at cycle wrt+lat; one GAP cycle; read wrt two cycles after done
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (x_wrt[b+2*k+1] - (x_wrt[b+2*k] + x_lat[b+2*k]) != 2) begin
                    n_fail++;
                    $display("FAIL rnd_gap%0d: got %0d, required 2",
                             k, x_wrt[b+2*k+1] - (x_wrt[b+2*k] + x_lat[b+2*k]));
                end
            end
            n_cmp++;
            if (rnd_cyc - x_wrt[b] != sum + 12) begin
                n_fail++;
                $display("FAIL rnd_length: got %0d, required %0d", rnd_cyc - x_wrt[b], sum + 12);
            end
            model_round(b);
            n_cmp++;
            if (lft_ld !== m_lft || rght_ld !== m_rght || batt !== m_batt) begin
                n_fail++;
                $display("FAIL rnd_regs: got %h %h %h, required %h %h %h",
                         lft_ld, rght_ld, batt, m_lft, m_rght, m_batt);
            end
        end
    endtask

    task automatic test_back_to_back();
        int b, r0, nc;
        b = n_x; r0 = rnd_cnt;
        pulse_nxt(nc);
        for (int p = 0; p < 3; p++) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            n_cmp++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_busy%0d: got %b, required 1", p, busy);
            end
            nxt = 1'b1;
            @(negedge clk);
            nxt = 1'b0;
        end
        wait_rnd(r0 + 2, "b2b");
        repeat (40) @(negedge clk);
        n_cmp++;
        if (rnd_cnt != r0 + 2 || n_x != b + 12 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_rounds: rounds %0d xfers %0d busy %b, required 2 12 0",
                     rnd_cnt - r0, n_x - b, busy);
        end
        model_round(b);
        model_round(b + 6);
        n_cmp++;
        if (lft_ld !== m_lft || rght_ld !== m_rght || batt !== m_batt) begin
            n_fail++;
            $display("FAIL b2b_regs: got %h %h %h, required %h %h %h",
                     lft_ld, rght_ld, batt, m_lft, m_rght, m_batt);
        end
    endtask

    task automatic test_done_collision();
        int b, r0, nc, k;
        b = n_x; r0 = rnd_cnt;
        pulse_nxt(nc);
        k = 0;
        while (rnd_done !== 1'b1 && k < 300) begin @(negedge clk); k++; end
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        wait_rnd(r0 + 2, "collide");
        repeat (20) @(negedge clk);
        n_cmp++;
        if (rnd_cnt != r0 + 2 || n_x != b + 12 || x_cmd[b+6] !== 16'h0000) begin
            n_fail++;
            $display("FAIL collide_rounds: rounds %0d xfers %0d cmd %h, required 2 12 0000",
                     rnd_cnt - r0, n_x - b, x_cmd[b+6]);
        end
        model_round(b);
        model_round(b + 6);
        n_cmp++;
        if (lft_ld !== m_lft || rght_ld !== m_rght || batt !== m_batt) begin
            n_fail++;
            $display("FAIL collide_regs: got %h %h %h, required %h %h %h",
                     lft_ld, rght_ld, batt, m_lft, m_rght, m_batt);
        end
    endtask

    task automatic test_timeout();
        int b, r0, t0, nc, k;
        b = n_x; r0 = rnd_cnt; t0 = n_tmo;
        hold_idx = b + 3;
        pulse_nxt(nc);
        k = 0;
        while (n_tmo == t0 && k < 1300) begin @(negedge clk); k++; end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (n_tmo != t0 + 1) begin
            n_fail++;
            $display("FAIL tmo_pulse: got %0d pulses, required 1", n_tmo - t0);
        end
        // spi_wrt cycle, then 1023 silent wait cycles, then the tmo_err cycle
        n_cmp++;
        if (tmo_cyc - x_wrt[b+3] != 1024 || x_cmd[b+3] !== 16'h2000) begin
            n_fail++;
            $display("FAIL tmo_time: got %0d cmd %h, required 1024 2000", tmo_cyc - x_wrt[b+3], x_cmd[b+3]);
        end
        n_cmp++;
        if (rnd_cnt != r0 || n_x != b + 4 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_abort: rounds %0d xfers %0d busy %b, required 0 4 0", rnd_cnt - r0, n_x - b, busy);
        end
        m_lft = mdl_upd(m_lft, m_primed[0], x_dat[b+1]);
        m_primed[0] = 1'b1;
        n_cmp++;
        if (lft_ld !== m_lft || rght_ld !== m_rght || batt !== m_batt) begin
            n_fail++;
            $display("FAIL tmo_regs: got %h %h %h, required %h %h %h",
                     lft_ld, rght_ld, batt, m_lft, m_rght, m_batt);
        end
        hold_idx = -1;
        b = n_x; r0 = rnd_cnt;
        pulse_nxt(nc);
        wait_rnd(r0 + 1, "tmo_recover");
        for (int j = 0; j < 6; j++) begin
            n_cmp++;
            if (x_cmd[b+j] !== exp_cmd(j)) begin
                n_fail++;
                $display("FAIL tmo_recover_cmd%0d: got %h, required %h", j, x_cmd[b+j], exp_cmd(j));
            end
        end
        model_round(b);
        n_cmp++;
        if (lft_ld !== m_lft || rght_ld !== m_rght || batt !== m_batt) begin
            n_fail++;
            $display("FAIL tmo_recover_regs: got %h %h %h, required %h %h %h",
                     lft_ld, rght_ld, batt, m_lft, m_rght, m_batt);
        end
    endtask

    task automatic test_reset_mid();
        int b, r0, nc;
        b = n_x;
        hold_idx = b;
        pulse_nxt(nc);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({spi_wrt, spi_cmd, lft_ld, rght_ld, batt, rnd_done, busy, tmo_err} !== 56'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h, required 0",
                     {spi_wrt, spi_cmd, lft_ld, rght_ld, batt, rnd_done, busy, tmo_err});
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hold_idx = -1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (n_x != b + 1) begin
            n_fail++;
            $display("FAIL midreset_idle: got %0d xfers, required 1", n_x - b);
        end
        b = n_x; r0 = rnd_cnt;
        pulse_nxt(nc);
        wait_rnd(r0 + 1, "midreset");
        model_round(b);
        n_cmp++;
        if (x_cmd[b] !== 16'h0000 || lft_ld !== m_lft || rght_ld !== m_rght || batt !== m_batt) begin
            n_fail++;
            $display("FAIL midreset_round: got %h %h %h %h, required 0000 %h %h %h",
                     x_cmd[b], lft_ld, rght_ld, batt, m_lft, m_rght, m_batt);
        end
    endtask

    task automatic test_avg();
        int b, r0, nc;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        for (int rnd = 0; rnd < 2; rnd++) begin
            b = n_x; r0 = rnd_cnt;
            data_q.push_back(16'($urandom));
            data_q.push_back({4'($urandom), (rnd == 0) ? 12'h100 : 12'h201});
            repeat (4) data_q.push_back(16'($urandom));
            pulse_nxt(nc);
            wait_rnd(r0 + 1, "avg");
            model_round(b);
            n_cmp++;
            if (lft_ld !== ((rnd == 0) ? 12'h100 : (AVG ? 12'h181 : 12'h201))) begin
                n_fail++;
                $display("FAIL avg_lft%0d: got %h, required %h", rnd, lft_ld,
                         (rnd == 0) ? 12'h100 : (AVG ? 12'h181 : 12'h201));
            end
            n_cmp++;
            if (rght_ld !== m_rght || batt !== m_batt) begin
                n_fail++;
                $display("FAIL avg_others%0d: got %h %h, required %h %h", rnd, rght_ld, batt, m_rght, m_batt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_rounds();
        test_back_to_back();
        test_done_collision();
        test_timeout();
        test_reset_mid();
        test_avg();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
